// File: rtl/rom_burst_reader.sv
// Constant-content ROM (identity, Gray or inverted) with a burst read
// engine streaming consecutive, wrapping words over valid/ready.
module rom_burst_reader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MODE       = 0,
  parameter int MAX_LEN    = 16,
  parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  ready,
  output logic [WIDTH-1:0]      data,
  output logic                  valid,
  output logic                  last,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0]  MAX_L   = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0]  ONE     = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  TWO     = LEN_WIDTH'(2);

  function automatic logic [WIDTH-1:0] word_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH-1:0] v;
    if (MODE == 1)      v = a ^ (a >> 1);
    else if (MODE == 2) v = ~a;
    else                v = a;
    return WIDTH'(v);
  endfunction

  state_t                r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n, w_addr_inc;
  logic [LEN_WIDTH-1:0]  r_rem, w_rem_n;
  logic [WIDTH-1:0]      r_data, w_data_n;
  logic                  r_valid, w_valid_n;
  logic                  r_last, w_last_n;
  logic                  r_err, w_err_n;
  logic                  w_ok;

  // Wrap by explicit compare so non-power-of-two depths never overrun
  assign w_addr_inc = (r_addr == LAST_A) ? '0 : r_addr + 1'b1;

  assign w_ok = (len != '0) && (len <= MAX_L) &&
                ({1'b0, start_addr} < DEPTH_W);

  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_rem_n   = r_rem;
    w_data_n  = r_data;
    w_valid_n = r_valid;
    w_last_n  = r_last;
    w_err_n   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (w_ok) begin
            w_state_n = RUN;
            w_addr_n  = start_addr;
            w_rem_n   = len;
            w_data_n  = word_of(start_addr);
            w_valid_n = 1'b1;
            w_last_n  = (len == ONE);
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (ready) begin
          if (r_rem > ONE) begin
            w_addr_n = w_addr_inc;
            w_rem_n  = r_rem - ONE;
            w_data_n = word_of(w_addr_inc);
            w_last_n = (r_rem == TWO);
          end else begin
            w_state_n = IDLE;
            w_data_n  = '0;
            w_valid_n = 1'b0;
            w_last_n  = 1'b0;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_rem   <= w_rem_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_last  <= w_last_n;
      r_err   <= w_err_n;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign last  = r_last;
  assign busy  = (r_state == RUN);
  assign err   = r_err;

endmodule
